ccsds123_sample_sequencer: RTL and testbench
============================================

# ccsds123_sample_sequencer

Input-side controller for the CCSDS-123 compressor core. Accepts raw samples in band-interleaved-by-pixel order (z fastest, then x, then y) from an AXI-Stream slave. Tags each sample with its (x, y, z) coordinates and the boundary flags the predictor needs, then forwards it downstream under valid/ready flow control. It also signals end-of-image and tracks the frame count, so the predictor and encoder never have to derive position themselves.

## Interface
- NX, 4, image width in pixels
- NY, 4, image height in lines
- NZ, 16, number of spectral bands
- D, 16, sample bit width
- clk  in  1  system clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  D  input sample
- s_axis_tvalid  in  1  input sample valid
- s_axis_tready  out  1  sequencer can accept a sample
- m_tdata  out  D  forwarded sample
- m_x  out  clog2(NX)  column of m_tdata
- m_y  out  clog2(NY)  line of m_tdata
- m_z  out  clog2(NZ)  band of m_tdata
- m_first_line  out  1  m_y == 0
- m_first_in_line  out  1  m_x == 0
- m_last_in_line  out  1  m_x == NX-1
- m_last_z  out  1  m_z == NZ-1
- m_last  out  1  final sample of the image (x=NX-1, y=NY-1, z=NZ-1)
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- frame_done  out  1  one-cycle pulse when the m_last sample transfers
- frame_count  out  16  number of completed frames; wraps modulo 2^16
- busy  out  1  a frame is partially accepted (any input counter nonzero) or output data is held

## Operation
- Input transfer happens when s_axis_tvalid && s_axis_tready. Output transfer happens when m_valid && m_ready.
- Input coordinate counters (z, x, y) advance on every input transfer, in this order:
  - z increments; at NZ-1 it wraps to 0 and x increments.
  - x wraps at NX-1 and carries into y.
  - y wraps at NY-1 back to 0, which starts the next frame.
- Coordinates and flags are computed from the counters before the increment, and are registered together with the data.
- frame_done pulses in the cycle after the output transfer of the m_last sample. frame_count increments in that same cycle.
- Counters are sized with clog2 of each dimension. Compare against NX-1, NY-1 and NZ-1 exactly; never rely on natural overflow. NX=1, NY=1 or NZ=1 must work: the corresponding counter stays at 0 and its last flag is always 1.
- Output data and tags never change while m_valid && !m_ready.
- A simultaneous input and output transfer in one cycle sustains one sample per clock.
- Reset mid-frame: all counters clear and held data is discarded. The next accepted sample is (0,0,0).

## Timing
- Reset values:
  - s_axis_tready=0 while areset is high, 1 in the first cycle after release.
  - m_valid=0, m_tdata=0, all coordinate and flag outputs 0.
  - frame_done=0, frame_count=0, busy=0.
- Latency: a sample accepted in cycle N presents m_valid in cycle N+1.
- Throughput: 1 sample/cycle with m_ready held high.
- Bubbles: gaps in s_axis_tvalid produce gaps in m_valid. Counters hold during gaps.

## Configuration
- SEQ_SKID_BUFFER_EN defined:
  - A 2-entry skid buffer sits between input and output.
  - s_axis_tready is a pure register output, with no combinational path from m_ready.
  - Full throughput is kept under any stall pattern.
- SEQ_SKID_BUFFER_EN undefined:
  - A single output register is used, with s_axis_tready = !m_valid || m_ready (combinational).
  - Latency and ordering are identical to the defined case.

## Structure
- Package ccsds123_seq_pkg holds:
  - struct seq_tag_t: x, y, z, first_line, first_in_line, last_in_line, last_z, last.
  - coordinate-width localparam functions.
  - FRAME_CNT_W=16.
- Sub-module ccsds123_skid_buf, parameterised on payload width. It carries data plus seq_tag_t and is instantiated only under SEQ_SKID_BUFFER_EN.

## Test plan
- Reset, then stream samples 0..255 contiguously with NX=4, NY=4, NZ=16 and m_ready=1:
  - outputs appear 1 cycle later with z cycling 0..15;
  - m_last_z every 16 samples;
  - m_first_in_line on samples 0–15, 64–79, etc.;
  - m_last only on sample 255;
  - frame_done once and frame_count=1.
- Random input bubbles (tvalid high 1 in 3 cycles) plus random m_ready stalls: output sequence equals input sequence, and tags hold stable during every stall.
- Two back-to-back frames without gaps: the second frame's first sample is (0,0,0) with m_first_line=1, and frame_count=2.
- Assert areset after 100 samples: all outputs return to reset values. A fresh 256-sample frame then completes normally with frame_count=1.
- m_ready held low for 20 cycles with input valid:
  - with SEQ_SKID_BUFFER_EN, at most 2 samples are absorbed and then s_axis_tready=0;
  - without it, at most 1;
  - no data is lost after release.
- NX=1, NY=1, NZ=1 build, one sample: m_first_line, m_first_in_line, m_last_in_line, m_last_z and m_last are all 1, and frame_done pulses.

Source files
------------

// File: rtl/ccsds123_seq_pkg.sv
// Shared types and sizing helpers for the CCSDS-123 sample sequencer.
package ccsds123_seq_pkg;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned COORD_MAX_W = 16;

  // A dimension of 1 still needs a 1-bit counter that simply stays at 0.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [COORD_MAX_W-1:0] x;
    logic [COORD_MAX_W-1:0] y;
    logic [COORD_MAX_W-1:0] z;
    logic                   first_line;
    logic                   first_in_line;
    logic                   last_in_line;
    logic                   last_z;
    logic                   last;
  } seq_tag_t;

endpackage

// File: rtl/ccsds123_sample_sequencer_if.sv
// Sample stream interface: raw AXI-Stream input and the tagged output stream.
interface ccsds123_sample_sequencer_if #(
  parameter int unsigned NX = 4,
  parameter int unsigned NY = 4,
  parameter int unsigned NZ = 16,
  parameter int unsigned D  = 16
);
  import ccsds123_seq_pkg::*;

  localparam int unsigned XW = coord_w(NX);
  localparam int unsigned YW = coord_w(NY);
  localparam int unsigned ZW = coord_w(NZ);

  logic [D-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [D-1:0]  m_tdata;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [ZW-1:0] m_z;
  logic          m_first_line;
  logic          m_first_in_line;
  logic          m_last_in_line;
  logic          m_last_z;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;

  // master: the sequencer; slave: upstream source plus downstream consumer.
  modport master (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_tdata, m_x, m_y, m_z, m_first_line, m_first_in_line, m_last_in_line,
    output m_last_z, m_last, m_valid,
    input  m_ready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_tdata, m_x, m_y, m_z, m_first_line, m_first_in_line, m_last_in_line,
    input  m_last_z, m_last, m_valid,
    output m_ready
  );

endinterface

// File: rtl/ccsds123_skid_buf.sv
// Two-entry skid buffer; input ready is a pure register with no path from out_ready_i.
module ccsds123_skid_buf
  import ccsds123_seq_pkg::*;
#(
  parameter int unsigned Width = 16 + $bits(seq_tag_t)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             occupied_o
);

  logic [Width-1:0] data_q, data_d, skid_q, skid_d;
  logic             valid_q, valid_d, skid_valid_q, skid_valid_d;
  logic             ready_q;
  logic             in_fire;

  assign in_fire = in_valid_i && ready_q;

  always_comb begin
    data_d       = data_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    if (!valid_q || out_ready_i) begin
      // Output slot frees up: the skid entry is older, so it goes first.
      if (skid_valid_q) begin
        data_d       = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        data_d  = in_data_i;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q       <= '0;
      skid_q       <= '0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      data_q       <= data_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign occupied_o  = valid_q || skid_valid_q;

endmodule

// File: rtl/ccsds123_sample_sequencer.sv
// Tags BIP-ordered samples with (x, y, z) and boundary flags and tracks frames.
// Define SEQ_SKID_BUFFER_EN for a registered-ready 2-entry skid buffer on the output.
module ccsds123_sample_sequencer
  import ccsds123_seq_pkg::*;
#(
  parameter int unsigned NX = 4,
  parameter int unsigned NY = 4,
  parameter int unsigned NZ = 16,
  parameter int unsigned D  = 16
) (
  input  logic                          clk,
  input  logic                          areset,
  ccsds123_sample_sequencer_if.master   bus_io,
  output logic                          frame_done,
  output logic [FRAME_CNT_W-1:0]        frame_count,
  output logic                          busy
);

  localparam int unsigned XW   = coord_w(NX);
  localparam int unsigned YW   = coord_w(NY);
  localparam int unsigned ZW   = coord_w(NZ);
  localparam int unsigned PayW = D + $bits(seq_tag_t);
  localparam logic [XW-1:0] XMax = XW'(NX - 1);
  localparam logic [YW-1:0] YMax = YW'(NY - 1);
  localparam logic [ZW-1:0] ZMax = ZW'(NZ - 1);

  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [ZW-1:0]          z_q, z_d;
  logic                   done_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  seq_tag_t               in_tag, out_tag;
  logic [PayW-1:0]        in_pay, out_pay;
  logic [D-1:0]           out_data;
  logic                   in_ready, in_fire, out_valid, out_fire, occupied;
  logic                   unused_coord_bits;

  always_comb begin
    in_tag               = '0;
    in_tag.x             = COORD_MAX_W'(x_q);
    in_tag.y             = COORD_MAX_W'(y_q);
    in_tag.z             = COORD_MAX_W'(z_q);
    in_tag.first_line    = (y_q == '0);
    in_tag.first_in_line = (x_q == '0);
    in_tag.last_in_line  = (x_q == XMax);
    in_tag.last_z        = (z_q == ZMax);
    in_tag.last          = (x_q == XMax) && (y_q == YMax) && (z_q == ZMax);
  end

  assign in_pay   = {bus_io.s_axis_tdata, in_tag};
  assign in_fire  = bus_io.s_axis_tvalid && in_ready;
  assign out_fire = out_valid && bus_io.m_ready;

  // z is fastest, then x, then y; explicit compares keep non-power-of-2 sizes correct.
  always_comb begin
    z_d = z_q;
    x_d = x_q;
    y_d = y_q;
    if (in_fire) begin
      if (in_tag.last_z) begin
        z_d = '0;
        if (in_tag.last_in_line) begin
          x_d = '0;
          y_d = (y_q == YMax) ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end else begin
        z_d = z_q + ZW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      done_q <= out_fire && out_tag.last;
      if (out_fire && out_tag.last) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

`ifdef SEQ_SKID_BUFFER_EN
  ccsds123_skid_buf #(
    .Width (PayW)
  ) u_skid_buf (
    .clk_i       (clk),
    .rst_i       (areset),
    .in_data_i   (in_pay),
    .in_valid_i  (bus_io.s_axis_tvalid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_pay),
    .out_valid_o (out_valid),
    .out_ready_i (bus_io.m_ready),
    .occupied_o  (occupied)
  );
`else
  logic [PayW-1:0] out_pay_q;
  logic            out_valid_q;
  logic            rdy_q;

  // rdy_q keeps ready low while reset is asserted.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_pay_q   <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (in_fire) begin
        out_pay_q   <= in_pay;
        out_valid_q <= 1'b1;
      end else if (bus_io.m_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready  = rdy_q && (!out_valid_q || bus_io.m_ready);
  assign out_pay   = out_pay_q;
  assign out_valid = out_valid_q;
  assign occupied  = out_valid_q;
`endif

  assign {out_data, out_tag} = out_pay;
  assign unused_coord_bits   = ^{out_tag.x, out_tag.y, out_tag.z};

  assign bus_io.s_axis_tready   = in_ready;
  assign bus_io.m_tdata         = out_data;
  assign bus_io.m_x             = out_tag.x[XW-1:0];
  assign bus_io.m_y             = out_tag.y[YW-1:0];
  assign bus_io.m_z             = out_tag.z[ZW-1:0];
  assign bus_io.m_first_line    = out_tag.first_line;
  assign bus_io.m_first_in_line = out_tag.first_in_line;
  assign bus_io.m_last_in_line  = out_tag.last_in_line;
  assign bus_io.m_last_z        = out_tag.last_z;
  assign bus_io.m_last          = out_tag.last;
  assign bus_io.m_valid         = out_valid;

  assign frame_done  = done_q;
  assign frame_count = frame_cnt_q;
  assign busy        = (x_q != '0) || (y_q != '0) || (z_q != '0) || occupied;

endmodule

// File: tb/tb_ccsds123_sample_sequencer.sv
// Scoreboard bench for ccsds123_sample_sequencer: a 4x4x16 instance plus a 1x1x1 instance.
module tb_ccsds123_sample_sequencer;

`ifdef SEQ_SKID_BUFFER_EN
  localparam int StallAbsorb = 2;
`else
  localparam int StallAbsorb = 1;
`endif

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  ccsds123_sample_sequencer_if #(.NX(4), .NY(4), .NZ(16), .D(16)) sif ();
  ccsds123_sample_sequencer_if #(.NX(1), .NY(1), .NZ(1), .D(16)) sif1 ();

  logic        frame_done, frame_done1, busy, busy1;
  logic [15:0] frame_count, frame_count1;

  ccsds123_sample_sequencer #(.NX(4), .NY(4), .NZ(16), .D(16)) u_dut (
    .clk         (clk),
    .areset      (areset),
    .bus_io      (sif),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .busy        (busy)
  );

  ccsds123_sample_sequencer #(.NX(1), .NY(1), .NZ(1), .D(16)) u_dut1 (
    .clk         (clk),
    .areset      (areset),
    .bus_io      (sif1),
    .frame_done  (frame_done1),
    .frame_count (frame_count1),
    .busy        (busy1)
  );

  int checks = 0;
  int failures = 0;

  logic ready_force = 1'b1;
  logic rnd_en = 1'b0;
  logic rnd_bit = 1'b1;
  logic lat_en = 1'b0;
  assign sif.m_ready  = rnd_en ? rnd_bit : ready_force;
  assign sif1.m_ready = 1'b1;

  logic [28:0] sb[$];
  int          sb_cyc[$];
  int          cyc = 0;
  int          in_idx = 0;
  int          out_cnt = 0;
  int          done_cnt = 0;
  logic        done_exp = 1'b0;
  logic [15:0] fc_exp = '0;
  logic        prev_stall = 1'b0;
  logic [28:0] prev_obs = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference tag from the sample's position within the frame (BIP order).
  function automatic logic [28:0] exp_vec(input int idx, input logic [15:0] d);
    int z = idx % 16;
    int x = (idx / 16) % 4;
    int y = idx / 64;
    return {d, 2'(x), 2'(y), 4'(z), y == 0, x == 0, x == 3, z == 15, idx == 255};
  endfunction

  function automatic logic [28:0] obs_vec();
    return {sif.m_tdata, sif.m_x, sif.m_y, sif.m_z, sif.m_first_line, sif.m_first_in_line,
            sif.m_last_in_line, sif.m_last_z, sif.m_last};
  endfunction

  always @(negedge clk) begin
    logic [28:0] obs, e;
    int c;
    cyc++;
    if (areset) begin
      sb.delete();
      sb_cyc.delete();
      in_idx     = 0;
      done_exp   = 1'b0;
      fc_exp     = '0;
      prev_stall = 1'b0;
    end else begin
      chk("frame_done", frame_done, done_exp);
      chk("frame_count", frame_count, fc_exp);
      if (frame_done) done_cnt++;
      obs = obs_vec();
      if (prev_stall) chk("stall_hold", {sif.m_valid, obs}, {1'b1, prev_obs});
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_obs   = obs;
      done_exp   = 1'b0;
      if (sif.m_valid && sif.m_ready) begin
        if (sb.size() == 0) begin
          chk("out_unexpected", sif.m_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          c = sb_cyc.pop_front();
          chk("out_sample", obs, e);
          if (lat_en) chk("latency", cyc - c, 1);
          if (e[0]) begin
            done_exp = 1'b1;
            fc_exp++;
          end
          out_cnt++;
        end
      end
      if (sif.s_axis_tvalid && sif.s_axis_tready) begin
        sb.push_back(exp_vec(in_idx, sif.s_axis_tdata));
        sb_cyc.push_back(cyc);
        in_idx = (in_idx + 1) % 256;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Presents one sample and returns 1 ns after the edge that accepts it.
  task automatic send(input logic [15:0] d);
    int   n = 0;
    logic acc = 1'b0;
    sif.s_axis_tdata  = d;
    sif.s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = sif.s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    sif.s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tready"}, sif.s_axis_tready, 1'b0);
    chk({tag, "_valid"}, sif.m_valid, 1'b0);
    chk({tag, "_data"}, sif.m_tdata, 16'h0);
    chk({tag, "_coords"}, {sif.m_x, sif.m_y, sif.m_z}, 8'h0);
    chk({tag, "_flags"}, {sif.m_first_line, sif.m_first_in_line, sif.m_last_in_line,
                          sif.m_last_z, sif.m_last}, 5'b0);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_count"}, frame_count, 16'h0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    time t0, t1;
    int  acc;
    logic took;
    areset = 1'b1;
    sif.s_axis_tvalid  = 1'b0;
    sif.s_axis_tdata   = '0;
    sif1.s_axis_tvalid = 1'b0;
    sif1.s_axis_tdata  = '0;

    // Reset values, then ready after release.
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    @(posedge clk);
    #1 areset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", sif.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;

    // One contiguous frame at full rate.
    lat_en = 1'b1;
    t0 = $time;
    for (int i = 0; i < 256; i++) send(16'(i));
    t1 = $time;
    idle(2);
    chk("throughput_cycles", (t1 - t0) / 10, 256);
    chk("f1_out_cnt", out_cnt, 256);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_count", frame_count, 16'd1);
    chk("f1_busy", busy, 1'b0);

    // Two back-to-back frames.
    for (int i = 0; i < 512; i++) send(16'(i) ^ 16'h5a5a);
    idle(2);
    chk("f3_done_cnt", done_cnt, 3);
    chk("f3_count", frame_count, 16'd3);

    // Input bubbles with random downstream stalls.
    lat_en = 1'b0;
    rnd_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(16'($urandom_range(0, 65535)));
      idle($urandom_range(0, 2));
    end
    rnd_en      = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    idle(2);
    chk("rnd_count", frame_count, 16'd4);
    chk("rnd_busy", busy, 1'b0);

    // Reset in the middle of a frame, then a fresh frame.
    lat_en = 1'b1;
    for (int i = 0; i < 100; i++) send(16'hA000 + 16'(i));
    sif.s_axis_tvalid = 1'b0;
    areset = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    @(posedge clk);
    #1 areset = 1'b0;
    idle(1);
    for (int i = 0; i < 256; i++) send(16'hB000 + 16'(i));
    idle(2);
    chk("post_rst_count", frame_count, 16'd1);
    chk("post_rst_busy", busy, 1'b0);

    // Long downstream stall with input held valid.
    lat_en      = 1'b0;
    ready_force = 1'b0;
    idle(1);
    acc = 0;
    sif.s_axis_tdata  = 16'hC000;
    sif.s_axis_tvalid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      took = sif.s_axis_tready;
      if (took) acc++;
      @(posedge clk);
      #1;
      if (took) sif.s_axis_tdata = sif.s_axis_tdata + 16'd1;
    end
    chk("stall_absorb", acc, StallAbsorb);
    chk("stall_tready", sif.s_axis_tready, 1'b0);
    sif.s_axis_tvalid = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    idle(1);
    chk("stall_busy_partial", busy, 1'b1);

    // Degenerate 1x1x1 image: every flag set, frame completes per sample.
    sif1.s_axis_tdata  = 16'hBEEF;
    sif1.s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("one_tready", sif1.s_axis_tready, 1'b1);
    @(posedge clk);
    #1 sif1.s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("one_valid", sif1.m_valid, 1'b1);
    chk("one_tag", {sif1.m_tdata, sif1.m_x, sif1.m_y, sif1.m_z, sif1.m_first_line,
                    sif1.m_first_in_line, sif1.m_last_in_line, sif1.m_last_z, sif1.m_last},
        {16'hBEEF, 3'b000, 5'b11111});
    @(negedge clk);
    chk("one_done", frame_done1, 1'b1);
    chk("one_count", frame_count1, 16'd1);
    @(negedge clk);
    chk("one_done_pulse", frame_done1, 1'b0);
    chk("one_busy", busy1, 1'b0);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
